// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared types and constants for the AXI SRAM slave
package axi_pkg;

  localparam int AXI_ID_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_DATA,
    ST_WR_RESP
  } slave_state_t;

  // burst kept as raw bits so the reserved encoding survives into the error check
  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [31:0]         addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
  } axi_req_t;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// rtl/axi_burst_addr.sv - next beat address and burst legality, shared by read and write paths
module axi_burst_addr
  import axi_pkg::*;
(
  input  logic [31:0] i_addr,
  input  logic [7:0]  i_len,
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_burst,
  output logic [31:0] o_next_addr,
  output logic        o_legal
);

  logic [31:0] w_beat;
  logic [31:0] w_incr;
  logic [31:0] w_mask;

  always_comb begin
    w_beat      = 32'd1 << i_size;
    w_incr      = i_addr + w_beat;
    w_mask      = (({24'd0, i_len} + 32'd1) << i_size) - 32'd1;
    o_next_addr = w_incr;
    o_legal     = (i_size <= 3'd2) && (i_burst != 2'b11) &&
                  ((i_burst != BURST_WRAP) || wrap_len_ok(i_len));
    case (i_burst)
      BURST_FIXED: o_next_addr = i_addr;
      BURST_WRAP:  o_next_addr = (i_addr & ~w_mask) | (w_incr & w_mask);
      default:     o_next_addr = w_incr;
    endcase
  end

endmodule

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - single-outstanding AXI3 responder backed by a word-addressed SRAM
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int MEM_AW = 14,
  parameter int ID_W   = AXI_ID_W
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic [7:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  input  logic            arvalid,
  output logic            arready,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid,
  input  logic            rready,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awaddr,
  input  logic [7:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic [1:0]      awburst,
  input  logic            awvalid,
  output logic            awready,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  input  logic            wvalid,
  output logic            wready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready
);

  slave_state_t r_state;
  slave_state_t w_next_state;
  axi_req_t     r_req;
  axi_req_t     w_in_req;
  axi_req_t     w_ba_req;
  logic [7:0]   r_cnt;
  logic         r_prio_wr;
  logic         r_werr;

  logic [31:0]  r_mem [2**MEM_AW];

  logic         w_ar_win;
  logic         w_aw_win;
  logic         w_ar_hs;
  logic         w_aw_hs;
  logic         w_r_hs;
  logic         w_w_hs;
  logic         w_b_hs;
  logic [31:0]  w_next_addr;
  logic         w_legal;
  logic         w_cnt_end;
  logic [31:0]  w_rd_addr;
  logic         w_rd_err;
  logic [31:0]  w_rd_word;
  logic         w_wr_err;
  logic         w_w_end;
  logic         w_werr_nxt;

  function automatic logic addr_oob(input logic [31:0] a);
    return |(a >> (MEM_AW + 2));
  endfunction

  assign w_ar_win = arvalid && (!awvalid || !r_prio_wr);
  assign w_aw_win = awvalid && (!arvalid || r_prio_wr);

  assign w_in_req = w_ar_win ?
      '{id: AXI_ID_W'(arid), addr: araddr, len: arlen, size: arsize, burst: arburst} :
      '{id: AXI_ID_W'(awid), addr: awaddr, len: awlen, size: awsize, burst: awburst};

  // In IDLE the address unit judges the request being offered, otherwise the latched burst
  assign w_ba_req = (r_state == ST_IDLE) ? w_in_req : r_req;

  axi_burst_addr u_burst_addr (
    .i_addr      (w_ba_req.addr),
    .i_len       (w_ba_req.len),
    .i_size      (w_ba_req.size),
    .i_burst     (w_ba_req.burst),
    .o_next_addr (w_next_addr),
    .o_legal     (w_legal)
  );

  assign w_ar_hs   = arvalid && arready;
  assign w_aw_hs   = awvalid && awready;
  assign w_r_hs    = rvalid && rready;
  assign w_w_hs    = wvalid && wready;
  assign w_b_hs    = bvalid && bready;
  assign w_cnt_end = (r_cnt == r_req.len);

  // First beat reads the offered address; later beats prefetch the next address
  assign w_rd_addr  = (r_state == ST_IDLE) ? w_in_req.addr : w_next_addr;
  assign w_rd_err   = !w_legal || addr_oob(w_rd_addr);
  assign w_rd_word  = r_mem[w_rd_addr[MEM_AW+1:2]];
  assign w_wr_err   = !w_legal || addr_oob(r_req.addr);
  assign w_w_end    = wlast || w_cnt_end;
  assign w_werr_nxt = r_werr || w_wr_err || (wlast != w_cnt_end);

  assign rid = ID_W'(r_req.id);
  assign bid = ID_W'(r_req.id);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_ar_hs)      w_next_state = ST_RD;
        else if (w_aw_hs) w_next_state = ST_WR_DATA;
      end
      ST_RD:      if (w_r_hs && rlast)    w_next_state = ST_IDLE;
      ST_WR_DATA: if (w_w_hs && w_w_end)  w_next_state = ST_WR_RESP;
      ST_WR_RESP: if (w_b_hs)             w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    arready = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    bvalid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        arready = aresetn && w_ar_win;
        awready = aresetn && w_aw_win;
      end
      ST_RD: begin
        rvalid = 1'b1;
        rlast  = w_cnt_end;
      end
      ST_WR_DATA: wready = 1'b1;
      ST_WR_RESP: bvalid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_req     <= '0;
      r_cnt     <= '0;
      r_prio_wr <= 1'b0;
      r_werr    <= 1'b0;
      rdata     <= '0;
      rresp     <= RESP_OKAY;
      bresp     <= RESP_OKAY;
    end else begin
      if (w_ar_hs) begin
        r_req     <= w_in_req;
        r_cnt     <= '0;
        r_prio_wr <= 1'b1;
        rdata     <= w_rd_err ? 32'd0 : w_rd_word;
        rresp     <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (w_aw_hs) begin
        r_req     <= w_in_req;
        r_cnt     <= '0;
        r_prio_wr <= 1'b0;
        r_werr    <= 1'b0;
      end else if (w_r_hs && !rlast) begin
        r_req.addr <= w_next_addr;
        r_cnt      <= r_cnt + 8'd1;
        rdata      <= w_rd_err ? 32'd0 : w_rd_word;
        rresp      <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (w_w_hs) begin
        r_req.addr <= w_next_addr;
        r_cnt      <= r_cnt + 8'd1;
        r_werr     <= w_werr_nxt;
        if (w_w_end) bresp <= w_werr_nxt ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // SRAM array carries no reset; erroneous beats never reach it
  always_ff @(posedge aclk) begin
    if (w_w_hs && !w_wr_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) r_mem[r_req.addr[MEM_AW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - directed table-driven bench for axi_sram_slave
module tb_axi_sram_slave;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  arid, awid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  axi_sram_slave dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] wbuf  [16];
  logic [31:0] ebuf  [16];
  logic [1:0]  erbuf [16];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic check_idle_outputs(input string nm);
    @(negedge aclk);
    chk({nm, "_arready"}, arready, 0);
    chk({nm, "_awready"}, awready, 0);
    chk({nm, "_rvalid"},  rvalid,  0);
    chk({nm, "_rlast"},   rlast,   0);
    chk({nm, "_wready"},  wready,  0);
    chk({nm, "_bvalid"},  bvalid,  0);
    chk({nm, "_rdata"},   rdata,   0);
    chk({nm, "_rresp"},   rresp,   0);
    chk({nm, "_bresp"},   bresp,   0);
    @(posedge aclk); #1;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] b, input string nm);
    int n = 0;
    arid = id; araddr = a; arlen = l; arsize = s; arburst = b; arvalid = 1'b1;
    @(negedge aclk);
    while (!arready && n < 50) begin @(negedge aclk); n++; end
    chk({nm, "_arready"}, arready, 1);
    @(posedge aclk); #1 arvalid = 1'b0;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] b, input string nm);
    int n = 0;
    awid = id; awaddr = a; awlen = l; awsize = s; awburst = b; awvalid = 1'b1;
    @(negedge aclk);
    while (!awready && n < 50) begin @(negedge aclk); n++; end
    chk({nm, "_awready"}, awready, 1);
    @(posedge aclk); #1 awvalid = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] b, input string nm);
    send_ar(id, a, l, s, b, nm);
    rready = 1'b1;
    for (int k = 0; k <= int'(l); k++) begin
      int n = 0;
      @(negedge aclk);
      while (!rvalid && n < 50) begin @(negedge aclk); n++; end
      chk($sformatf("%s_b%0d_gap", nm, k),   n,     0);
      chk($sformatf("%s_b%0d_rdata", nm, k), rdata, ebuf[k]);
      chk($sformatf("%s_b%0d_rresp", nm, k), rresp, erbuf[k]);
      chk($sformatf("%s_b%0d_rlast", nm, k), rlast, (k == int'(l)) ? 1 : 0);
      chk($sformatf("%s_b%0d_rid", nm, k),   rid,   id);
      @(posedge aclk); #1;
    end
    rready = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [1:0] b, input logic [3:0] strb,
                          input int last_at, input logic [1:0] exp_b, input string nm);
    int n;
    send_aw(id, a, l, s, b, nm);
    for (int k = 0; k <= last_at; k++) begin
      n = 0;
      wdata = wbuf[k]; wstrb = strb; wlast = (k == last_at); wvalid = 1'b1;
      @(negedge aclk);
      while (!wready && n < 50) begin @(negedge aclk); n++; end
      chk($sformatf("%s_w%0d_wready", nm, k), wready, 1);
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!bvalid && n < 50) begin @(negedge aclk); n++; end
    chk({nm, "_bgap"},  n,     0);
    chk({nm, "_bresp"}, bresp, exp_b);
    chk({nm, "_bid"},   bid,   id);
    @(posedge aclk); #1 bready = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; rready = 1'b0; bready = 1'b0;

    vt[0]  = '{1'b1, 32'h0000_0100, 3'd2, 2'b01, 32'hDEAD_BEEF, 4'hF,    32'h0,         2'b00};
    vt[1]  = '{1'b0, 32'h0000_0100, 3'd2, 2'b01, 32'h0,         4'h0,    32'hDEAD_BEEF, 2'b00};
    vt[2]  = '{1'b1, 32'h0000_0140, 3'd2, 2'b01, 32'h1122_3344, 4'hF,    32'h0,         2'b00};
    vt[3]  = '{1'b1, 32'h0000_0140, 3'd2, 2'b01, 32'h0000_AB00, 4'b0010, 32'h0,         2'b00};
    vt[4]  = '{1'b0, 32'h0000_0140, 3'd2, 2'b01, 32'h0,         4'h0,    32'h1122_AB44, 2'b00};
    vt[5]  = '{1'b0, 32'h8000_0000, 3'd2, 2'b01, 32'h0,         4'h0,    32'h0,         2'b10};
    vt[6]  = '{1'b1, 32'h0000_0000, 3'd2, 2'b01, 32'h0BAD_F00D, 4'hF,    32'h0,         2'b00};
    vt[7]  = '{1'b1, 32'h0001_0000, 3'd2, 2'b01, 32'h7777_7777, 4'hF,    32'h0,         2'b10};
    vt[8]  = '{1'b0, 32'h0000_0000, 3'd2, 2'b01, 32'h0,         4'h0,    32'h0BAD_F00D, 2'b00};
    vt[9]  = '{1'b0, 32'h0000_0100, 3'd3, 2'b01, 32'h0,         4'h0,    32'h0,         2'b10};
    vt[10] = '{1'b1, 32'h0000_0180, 3'd2, 2'b00, 32'hCAFE_F00D, 4'hF,    32'h0,         2'b00};
    vt[11] = '{1'b0, 32'h0000_0180, 3'd2, 2'b00, 32'h0,         4'h0,    32'hCAFE_F00D, 2'b00};
    vt[12] = '{1'b0, 32'h0000_0180, 3'd2, 2'b11, 32'h0,         4'h0,    32'h0,         2'b10};
    vt[13] = '{1'b0, 32'h0000_0100, 3'd2, 2'b10, 32'h0,         4'h0,    32'h0,         2'b10};

    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    check_idle_outputs("reset");

    for (int i = 0; i < 14; i++) begin
      if (vt[i].wr) begin
        wbuf[0] = vt[i].wdata;
        do_write(4'(i), vt[i].addr, 8'd0, vt[i].size, vt[i].burst, vt[i].strb, 0,
                 vt[i].exp_resp, $sformatf("vec%0d", i));
      end else begin
        ebuf[0] = vt[i].exp_data; erbuf[0] = vt[i].exp_resp;
        do_read(4'(i), vt[i].addr, 8'd0, vt[i].size, vt[i].burst, $sformatf("vec%0d", i));
      end
    end

    // Preload words 0x80..0x83 and 0x40..0x43 with INCR bursts
    for (int k = 0; k < 4; k++) wbuf[k] = 32'hA000_0000 + 32'(k);
    do_write(4'h3, 32'h200, 8'd3, 3'd2, 2'b01, 4'hF, 3, 2'b00, "pre_a");
    for (int k = 0; k < 4; k++) wbuf[k] = 32'hB000_0000 + 32'(k);
    do_write(4'h4, 32'h100, 8'd3, 3'd2, 2'b01, 4'hF, 3, 2'b00, "pre_b");

    for (int k = 0; k < 4; k++) begin ebuf[k] = 32'hA000_0000 + 32'(k); erbuf[k] = 2'b00; end
    do_read(4'h5, 32'h200, 8'd3, 3'd2, 2'b01, "incr4");

    ebuf[0] = 32'hB000_0003; ebuf[1] = 32'hB000_0000;
    ebuf[2] = 32'hB000_0001; ebuf[3] = 32'hB000_0002;
    do_read(4'h6, 32'h10C, 8'd3, 3'd2, 2'b10, "wrap4");

    // Stall: rready low for five cycles with the first beat presented
    send_ar(4'h7, 32'h200, 8'd1, 3'd2, 2'b01, "stall");
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      chk($sformatf("stall_c%0d_rvalid", c), rvalid, 1);
      chk($sformatf("stall_c%0d_rdata", c),  rdata,  32'hA000_0000);
      chk($sformatf("stall_c%0d_rlast", c),  rlast,  0);
      @(posedge aclk); #1;
    end
    rready = 1'b1;
    @(negedge aclk);
    chk("stall_b0_rdata", rdata, 32'hA000_0000);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("stall_b1_rdata", rdata, 32'hA000_0001);
    chk("stall_b1_rlast", rlast, 1);
    @(posedge aclk); #1 rready = 1'b0;

    // wlast at beat 1 of a 4-beat burst
    wbuf[0] = 32'h3030_3030; wbuf[1] = 32'h3131_3131;
    do_write(4'h8, 32'h300, 8'd3, 3'd2, 2'b01, 4'hF, 1, 2'b10, "early");
    ebuf[0] = 32'h3030_3030; erbuf[0] = 2'b00;
    do_read(4'h9, 32'h300, 8'd0, 3'd2, 2'b01, "after_early");

    // Reset mid-run, then AR/AW collisions
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    check_idle_outputs("reset2");

    arid = 4'h1; araddr = 32'h200; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    awid = 4'h2; awaddr = 32'h400; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    @(negedge aclk);
    chk("col1_arready", arready, 1);
    chk("col1_awready", awready, 0);
    @(posedge aclk); #1 arvalid = 1'b0; rready = 1'b1;
    @(negedge aclk);
    chk("col1_rvalid",  rvalid,  1);
    chk("col1_rdata",   rdata,   32'hA000_0000);
    chk("col1_rid",     rid,     4'h1);
    chk("col1_awblock", awready, 0);
    @(posedge aclk); #1 rready = 1'b0; araddr = 32'h204; arvalid = 1'b1;
    @(negedge aclk);
    chk("col2_awready", awready, 1);
    chk("col2_arready", arready, 0);
    @(posedge aclk); #1 awvalid = 1'b0;
    wdata = 32'h1234_5678; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    @(negedge aclk);
    chk("col2_wready",  wready,  1);
    chk("col2_arblock", arready, 0);
    @(posedge aclk); #1 wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    @(negedge aclk);
    chk("col2_bvalid", bvalid, 1);
    chk("col2_bresp",  bresp,  2'b00);
    chk("col2_bid",    bid,    4'h2);
    @(posedge aclk); #1 bready = 1'b0;
    @(negedge aclk);
    chk("col3_arready", arready, 1);
    @(posedge aclk); #1 arvalid = 1'b0; rready = 1'b1;
    @(negedge aclk);
    chk("col3_rdata", rdata, 32'hA000_0001);
    chk("col3_rlast", rlast, 1);
    @(posedge aclk); #1 rready = 1'b0;

    ebuf[0] = 32'h1234_5678; erbuf[0] = 2'b00;
    do_read(4'hA, 32'h400, 8'd0, 3'd2, 2'b01, "col_wr_back");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI3-style responder that terminates the core's AXI master port for simulation and FPGA bring-up.
- Backs the port with an on-chip word-addressed SRAM.
- Serves one burst at a time, read or write, with fair arbitration between AR and AW.
- Sits between core_top's AXI outputs and the SoC top, as the memory-side counterpart of the core's master.

Parameters:
- MEM_AW, 14, word-address width; memory holds 2^MEM_AW 32-bit words (default 64 KiB).
- ID_W, 4, width of arid/rid/awid/bid.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- arid  in  ID_W  read ID
- araddr  in  32  read byte address
- arlen  in  8  beats minus 1
- arsize  in  3  log2 bytes per beat
- arburst  in  2  burst type
- arvalid  in  1  read request valid
- arready  out  1  read request accepted
- rid  out  ID_W  echoes arid
- rdata  out  32  read data
- rresp  out  2  read response
- rlast  out  1  final read beat
- rvalid  out  1  read data valid
- rready  in  1  read data accepted
- awid  in  ID_W  write ID
- awaddr  in  32  write byte address
- awlen  in  8  beats minus 1
- awsize  in  3  log2 bytes per beat
- awburst  in  2  burst type
- awvalid  in  1  write request valid
- awready  out  1  write request accepted
- wdata  in  32  write data
- wstrb  in  4  byte enables
- wlast  in  1  final write beat
- wvalid  in  1  write data valid
- wready  out  1  write data accepted
- bid  out  ID_W  echoes awid
- bresp  out  2  write response
- bvalid  out  1  write response valid
- bready  in  1  write response accepted
- Lock/cache/prot/wid are not ported. The top leaves them unconnected.

Behaviour:
- Reset (aresetn low, asynchronous):
  - State goes to IDLE.
  - arready, awready, rvalid, rlast, wready, bvalid go to 0.
  - rdata, rresp, bresp, rid, bid go to 0.
  - The priority flag selects read.
  - SRAM contents are not reset.
  - Reset mid-burst abandons the burst with no response.
- FSM states: IDLE, RD, WR_DATA, WR_RESP.
- IDLE:
  - arready=1 when arvalid is high and either awvalid is low or priority=read.
  - awready=1 when awvalid is high and either arvalid is low or priority=write.
  - Exactly one handshake can occur per cycle.
  - A handshake latches id, addr, len, size, burst and a beat counter of 0.
  - A handshake flips priority to the other direction.
  - AR handshake goes to RD; AW handshake goes to WR_DATA.
  - arready/awready are 0 in every other state.
- RD:
  - The first rvalid comes 1 cycle after the AR handshake.
  - rdata is registered. On each R handshake the next beat's data loads in the same edge, so with rready held high there is one beat per cycle.
  - rlast=1 when counter==len.
  - The R handshake with rlast returns to IDLE; arready may rise the following cycle.
  - rvalid stays held until rready; all R outputs are stable while stalled.
- WR_DATA:
  - wready=1.
  - Each W handshake writes the bytes enabled by wstrb and advances addr and counter.
  - The handshake with wlast goes to WR_RESP.
  - If wlast arrives at counter!=len, the burst terminates there and the sticky error is set.
- WR_RESP:
  - bvalid=1, starting the cycle after the last W handshake.
  - bresp is OKAY (00), or SLVERR (10) if the sticky error is set.
  - A B handshake returns to IDLE.
- Address generation, with beat size 1<<size:
  - FIXED (00): the address holds.
  - INCR (01): the address adds the beat size and wraps at 2^32.
  - WRAP (10): the address wraps within the aligned (len+1)*beat-size boundary; only len ∈ {1,3,7,15} is legal.
  - Reserved (11) is treated as INCR with the error flagged.
- Errors give SLVERR on the affected R beat, or sticky into bresp. Error conditions:
  - address bits [31:MEM_AW+2] nonzero
  - size>2
  - illegal WRAP len
  - reserved burst type
- Error beats read rdata=0; error write beats are dropped.
- The SRAM index is addr[MEM_AW+1:2]; sub-word reads return the full word.

Decomposition:
- axi_pkg holds:
  - burst_t enum (FIXED/INCR/WRAP)
  - RESP_OKAY/RESP_SLVERR constants
  - slave_state_t enum
  - an ar/aw request struct (id, addr, len, size, burst)
- One sub-module, axi_burst_addr: combinational next-address from addr, size, len, burst, plus a legality flag. It is shared by the read and write paths.

Test Plan:
- Single INCR write of 0xDEADBEEF with wstrb=4'b1111 to 0x100, then a read of 0x100 -> bresp=00; rdata=0xDEADBEEF, rlast=1, rresp=00.
- INCR read at 0x200 with arlen=3 and rready held high -> 4 consecutive beats from words 0x80..0x83; rlast on beat 3 only.
- WRAP read at 0x10C with arlen=3, size=2 -> addresses 0x10C, 0x100, 0x104, 0x108.
- Simultaneous arvalid and awvalid from reset -> read served first, then write. Repeat the collision -> the write is served first (alternation).
- Write with wstrb=4'b0010 and wdata=0x0000AB00 over 0x11223344 -> a read returns 0x1122AB44. Then rready held low for 5 cycles mid-burst -> rdata and rvalid stay stable.
- Read at 0x8000_0000, and a write ending with wlast early at counter 1 of awlen=3 -> rresp=10 with rdata=0; bresp=10; the FSM returns to IDLE.
